// File: rtl/riscv_core_dcache_writeback.sv
// Data-cache writeback master: buffers one dirty block and sends it as a single AXI4 INCR write burst.
// Optional macro RISCV_DCACHE_WB_ERR_EN adds a sticky o_wb_error flag for bad B responses.
module riscv_core_dcache_writeback #(
  parameter int ADDR_WIDTH     = 64,
  parameter int BLOCK_WIDTH    = 256,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int ID_WIDTH       = 4,
  parameter int WB_ID          = 0
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_wb_req,
  input  logic [ADDR_WIDTH-1:0]         i_wb_addr,
  input  logic [BLOCK_WIDTH-1:0]        i_wb_block,
  output logic                          o_wb_ready,
  output logic                          o_wb_done,
  output logic [ID_WIDTH-1:0]           o_awid,
  output logic [ADDR_WIDTH-1:0]         o_awaddr,
  output logic [7:0]                    o_awlen,
  output logic [2:0]                    o_awsize,
  output logic [1:0]                    o_awburst,
  output logic                          o_awvalid,
  input  logic                          i_awready,
  output logic [AXI_DATA_WIDTH-1:0]     o_wdata,
  output logic [AXI_DATA_WIDTH/8-1:0]   o_wstrb,
  output logic                          o_wlast,
  output logic                          o_wvalid,
  input  logic                          i_wready,
  input  logic [ID_WIDTH-1:0]           i_bid,
  input  logic [1:0]                    i_bresp,
  input  logic                          i_bvalid,
  output logic                          o_bready,
  output logic [1:0]                    o_dbg_state
`ifdef RISCV_DCACHE_WB_ERR_EN
  ,
  output logic                          o_wb_error
`endif
);

  localparam int BEATS  = BLOCK_WIDTH / AXI_DATA_WIDTH;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int OFF_W  = $clog2(BLOCK_WIDTH / 8);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  // Handshake rule on every channel: a transfer happens on a rising clock edge where
  // valid && ready; once valid is raised it and its payload hold until that edge.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e                    state_q;
  logic [ADDR_WIDTH-1:0]     addr_q;
  logic [BLOCK_WIDTH-1:0]    block_q;
  logic [BEAT_W-1:0]         beat_q;
  logic                      aw_done_q;
  logic                      w_done_q;
  logic                      awvalid_q;
  logic                      wvalid_q;
  logic                      bready_q;
  logic                      ready_q;
  logic                      done_q;

  logic aw_hs;
  logic w_hs;
  logic beat_is_last;
  logic aw_done_d;
  logic w_done_d;
  logic b_hs;

  assign aw_hs        = awvalid_q && i_awready;
  assign w_hs         = wvalid_q && i_wready;
  assign beat_is_last = (beat_q == LAST_BEAT);
  assign aw_done_d    = aw_done_q || aw_hs;
  assign w_done_d     = w_done_q || (w_hs && beat_is_last);
  assign b_hs         = bready_q && i_bvalid;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      block_q   <= '0;
      beat_q    <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (i_wb_req) begin
            addr_q    <= {i_wb_addr[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
            block_q   <= i_wb_block;
            beat_q    <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            awvalid_q <= 1'b1;
            wvalid_q  <= 1'b1;
            ready_q   <= 1'b0;
            state_q   <= SEND;
          end
        end
        SEND: begin
          if (aw_hs) begin
            awvalid_q <= 1'b0;
            aw_done_q <= 1'b1;
          end
          // The buffer shifts down one word per beat so the current beat is always the low word.
          if (w_hs) begin
            if (beat_is_last) begin
              wvalid_q <= 1'b0;
              w_done_q <= 1'b1;
            end else begin
              beat_q  <= beat_q + BEAT_W'(1);
              block_q <= {{AXI_DATA_WIDTH{1'b0}}, block_q[BLOCK_WIDTH-1:AXI_DATA_WIDTH]};
            end
          end
          if (aw_done_d && w_done_d) begin
            bready_q <= 1'b1;
            state_q  <= RESP;
          end
        end
        RESP: begin
          if (i_bvalid) begin
            bready_q <= 1'b0;
            done_q   <= 1'b1;
            ready_q  <= 1'b1;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef RISCV_DCACHE_WB_ERR_EN
  logic err_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      err_q <= 1'b0;
    end else if (b_hs && (i_bresp[1] || (i_bid != ID_WIDTH'(WB_ID)))) begin
      err_q <= 1'b1;
    end
  end

  assign o_wb_error = err_q;

  logic unused_inputs;
  assign unused_inputs = ^{i_wb_addr[OFF_W-1:0], i_bresp[0]};
`else
  logic unused_inputs;
  assign unused_inputs = ^{i_wb_addr[OFF_W-1:0], i_bid, i_bresp, b_hs};
`endif

  assign o_wb_ready  = ready_q;
  assign o_wb_done   = done_q;
  assign o_awid      = ID_WIDTH'(WB_ID);
  assign o_awaddr    = addr_q;
  assign o_awlen     = 8'(BEATS - 1);
  assign o_awsize    = 3'($clog2(AXI_DATA_WIDTH / 8));
  assign o_awburst   = 2'b01;
  assign o_awvalid   = awvalid_q;
  assign o_wdata     = block_q[AXI_DATA_WIDTH-1:0];
  assign o_wstrb     = '1;
  assign o_wlast     = wvalid_q && beat_is_last;
  assign o_wvalid    = wvalid_q;
  assign o_bready    = bready_q;
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_riscv_core_dcache_writeback.sv
// Directed bench for riscv_core_dcache_writeback: AXI slave model, beat/address scoreboard, summary line.
module tb_riscv_core_dcache_writeback;
  localparam int AW = 64;
  localparam int BW = 256;
  localparam int DW = 64;
  localparam int IW = 4;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic            wb_req = 1'b0;
  logic [AW-1:0]   wb_addr = '0;
  logic [BW-1:0]   wb_block = '0;
  logic            wb_ready, wb_done;
  logic [IW-1:0]   awid;
  logic [AW-1:0]   awaddr;
  logic [7:0]      awlen;
  logic [2:0]      awsize;
  logic [1:0]      awburst;
  logic            awvalid;
  logic            awready;
  logic [DW-1:0]   wdata;
  logic [DW/8-1:0] wstrb;
  logic            wlast, wvalid;
  logic            wready;
  logic [IW-1:0]   bid = '0;
  logic [1:0]      bresp = 2'b00;
  logic            bvalid;
  logic            bready;
  logic [1:0]      dbg_state;
`ifdef RISCV_DCACHE_WB_ERR_EN
  logic            wb_error;
`endif

  riscv_core_dcache_writeback dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_wb_req(wb_req), .i_wb_addr(wb_addr), .i_wb_block(wb_block),
    .o_wb_ready(wb_ready), .o_wb_done(wb_done),
    .o_awid(awid), .o_awaddr(awaddr), .o_awlen(awlen), .o_awsize(awsize),
    .o_awburst(awburst), .o_awvalid(awvalid), .i_awready(awready),
    .o_wdata(wdata), .o_wstrb(wstrb), .o_wlast(wlast), .o_wvalid(wvalid),
    .i_wready(wready), .i_bid(bid), .i_bresp(bresp), .i_bvalid(bvalid),
    .o_bready(bready), .o_dbg_state(dbg_state)
`ifdef RISCV_DCACHE_WB_ERR_EN
    , .o_wb_error(wb_error)
`endif
  );

  // scoreboard
  int n_tests = 0;
  int n_fail  = 0;
  logic [DW-1:0] exp_q[$];
  logic [AW-1:0] exp_addr_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [BW-1:0] make_block(input logic [7:0] base);
    logic [BW-1:0] r;
    r = '0;
    for (int n = 0; n < 32; n++) r[8*n +: 8] = base + 8'(n);
    return r;
  endfunction

  function automatic logic [DW-1:0] make_beat(input logic [7:0] base, input int k);
    logic [DW-1:0] r;
    for (int j = 0; j < 8; j++) r[8*j +: 8] = base + 8'(8*k + j);
    return r;
  endfunction

  // monitor state, sampled on the falling edge
  int cyc = 0, acc_cyc = 0, w_beats = 0, done_cnt = 0, acc_cnt = 0;
  bit aw_seen = 0, chk_lat = 0, chk_w_first = 0, chk_busy = 0;
  bit prev_done = 0, prev_bready = 0, prev_aw_stall = 0, prev_w_stall = 0, prev_wlast = 0;
  logic [AW-1:0] prev_awaddr = '0;
  logic [DW-1:0] prev_wdata = '0;
  bit hs_aw_n = 0, hs_wlast_n = 0, hs_b_n = 0;

  initial forever begin
    @(negedge clk);
    cyc++;
    if (!rst_n) begin
      hs_aw_n = 0; hs_wlast_n = 0; hs_b_n = 0;
      prev_done = 0; prev_bready = 0; prev_aw_stall = 0; prev_w_stall = 0;
    end else begin
      if (wb_done) begin
        check("done_pulse_width", 64'(prev_done), 0);
        done_cnt++;
        if (chk_lat) check("done_latency", 64'(cyc - acc_cyc), 6);
      end
      prev_done = wb_done;
      if (bready && !prev_bready) begin
        check("resp_after_aw", 64'(aw_seen), 1);
        check("resp_after_w", 64'(w_beats), 4);
      end
      prev_bready = bready;
      if (prev_aw_stall) begin
        check("awvalid_hold", 64'(awvalid), 1);
        check("awaddr_hold", awaddr, prev_awaddr);
      end
      if (prev_w_stall) begin
        check("wvalid_hold", 64'(wvalid), 1);
        check("wdata_hold", wdata, prev_wdata);
        check("wlast_hold", 64'(wlast), 64'(prev_wlast));
      end
      prev_aw_stall = awvalid && !awready;
      prev_awaddr   = awaddr;
      prev_w_stall  = wvalid && !wready;
      prev_wdata    = wdata;
      prev_wlast    = wlast;
      hs_aw_n    = awvalid && awready;
      hs_wlast_n = wvalid && wready && wlast;
      hs_b_n     = bvalid && bready;
      if (hs_aw_n) begin
        if (exp_addr_q.size() == 0) check("awaddr_unexpected", 1, 0);
        else check("awaddr", awaddr, exp_addr_q.pop_front());
        check("awlen", 64'(awlen), 3);
        check("awsize", 64'(awsize), 3);
        check("awburst", 64'(awburst), 1);
        check("awid", 64'(awid), 0);
        if (chk_w_first) check("w_before_aw", 64'(w_beats), 4);
        aw_seen = 1;
      end
      if (wvalid && wready) begin
        if (exp_q.size() == 0) check("wdata_unexpected", 1, 0);
        else check("wdata", wdata, exp_q.pop_front());
        check("wlast", 64'(wlast), 64'(w_beats == 3));
        check("wstrb", 64'(wstrb), 64'hff);
        w_beats++;
      end
      if (wb_req && wb_ready) begin
        acc_cnt++;
        acc_cyc = cyc;
        if (chk_busy && acc_cnt == 2) check("busy_accept_on_done", 64'(wb_done), 1);
        w_beats = 0;
        aw_seen = 0;
      end
    end
  end

  // AXI slave model, drives just after the rising edge
  int aw_hold = 0;
  bit w_toggle = 0;
  bit aw_got = 0, wl_got = 0;

  initial begin
    awready = 1'b1;
    wready  = 1'b1;
    bvalid  = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        bvalid = 1'b0; aw_got = 0; wl_got = 0; awready = 1'b1; wready = 1'b1;
      end else begin
        awready = (aw_hold == 0);
        if (awvalid && aw_hold > 0) aw_hold--;
        wready = w_toggle ? ~wready : 1'b1;
        if (hs_b_n) begin
          bvalid = 1'b0; aw_got = 0; wl_got = 0;
        end else begin
          if (hs_aw_n) aw_got = 1;
          if (hs_wlast_n) wl_got = 1;
          if (aw_got && wl_got) bvalid = 1'b1;
        end
      end
    end
  end

  // driver tasks
  task automatic start_test();
    done_cnt = 0; acc_cnt = 0;
    chk_lat = 0; chk_w_first = 0; chk_busy = 0;
    aw_hold = 0; w_toggle = 0;
  endtask

  task automatic push_exp(input logic [AW-1:0] a, input logic [7:0] base);
    exp_addr_q.push_back(a);
    for (int k = 0; k < 4; k++) exp_q.push_back(make_beat(base, k));
  endtask

  task automatic do_req(input logic [AW-1:0] a, input logic [BW-1:0] b);
    bit acc;
    acc = 0;
    @(posedge clk);
    #1;
    wb_req = 1'b1; wb_addr = a; wb_block = b;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (wb_ready) begin acc = 1; break; end
    end
    if (!acc) check("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    wb_req = 1'b0;
  endtask

  task automatic wait_done(input int n);
    for (int i = 0; i < 200 && done_cnt < n; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    check("done_count", 64'(done_cnt), 64'(n));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    wb_req = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    do_reset();
    // reset values
    check("rst_wb_ready", 64'(wb_ready), 1);
    check("rst_awvalid", 64'(awvalid), 0);
    check("rst_wvalid", 64'(wvalid), 0);
    check("rst_wlast", 64'(wlast), 0);
    check("rst_bready", 64'(bready), 0);
    check("rst_wb_done", 64'(wb_done), 0);
    check("rst_wdata", wdata, 0);
    check("rst_state", 64'(dbg_state), 0);
`ifdef RISCV_DCACHE_WB_ERR_EN
    check("rst_wb_error", 64'(wb_error), 0);
`endif

    // zero-wait burst with hand-written beats
    start_test();
    chk_lat = 1;
    exp_addr_q.push_back(64'h1220);
    exp_q.push_back(64'h0706050403020100);
    exp_q.push_back(64'h0f0e0d0c0b0a0908);
    exp_q.push_back(64'h1716151413121110);
    exp_q.push_back(64'h1f1e1d1c1b1a1918);
    do_req(64'h0000_1234,
           256'h1f1e1d1c1b1a191817161514131211100f0e0d0c0b0a09080706050403020100);
    wait_done(1);
    check("zw_beats", 64'(w_beats), 4);
    check("zw_expq_empty", 64'(exp_q.size()), 0);

    // AW backpressure: all W beats go first
    start_test();
    aw_hold = 5;
    chk_w_first = 1;
    push_exp(64'h8000, 8'h40);
    do_req(64'h8001, make_block(8'h40));
    wait_done(1);
    check("bp_beats", 64'(w_beats), 4);

    // toggling wready, top-of-memory block
    start_test();
    w_toggle = 1;
    push_exp(64'hffff_ffff_ffff_ffe0, 8'h80);
    do_req(64'hffff_ffff_ffff_ffff, make_block(8'h80));
    wait_done(1);
    check("tog_beats", 64'(w_beats), 4);
    w_toggle = 0;

    // request while busy is held until the first burst completes
    start_test();
    chk_busy = 1;
    push_exp(64'h40, 8'h11);
    push_exp(64'h60, 8'h22);
    do_req(64'h40, make_block(8'h11));
    do_req(64'h77, make_block(8'h22));
    wait_done(2);
    check("busy_accepts", 64'(acc_cnt), 2);
    check("busy_expq_empty", 64'(exp_addr_q.size()), 0);

    // reset after beat 1 aborts the burst
    start_test();
    push_exp(64'h100, 8'h33);
    do_req(64'h100, make_block(8'h33));
    for (int i = 0; i < 50 && w_beats < 2; i++) @(negedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_awvalid", 64'(awvalid), 0);
    check("mid_rst_wvalid", 64'(wvalid), 0);
    check("mid_rst_wlast", 64'(wlast), 0);
    check("mid_rst_bready", 64'(bready), 0);
    check("mid_rst_wb_ready", 64'(wb_ready), 1);
    check("mid_rst_wdata", wdata, 0);
    exp_q.delete();
    exp_addr_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    start_test();
    push_exp(64'h200, 8'h55);
    do_req(64'h21f, make_block(8'h55));
    wait_done(1);
    check("post_rst_beats", 64'(w_beats), 4);

`ifdef RISCV_DCACHE_WB_ERR_EN
    start_test();
    bresp = 2'b10;
    push_exp(64'h1000, 8'h66);
    do_req(64'h1000, make_block(8'h66));
    wait_done(1);
    check("err_slverr", 64'(wb_error), 1);
    bresp = 2'b00;
    start_test();
    push_exp(64'h1020, 8'h77);
    do_req(64'h1020, make_block(8'h77));
    wait_done(1);
    check("err_sticky", 64'(wb_error), 1);
    do_reset();
    check("err_cleared", 64'(wb_error), 0);
    start_test();
    bid = 4'd5;
    push_exp(64'h1040, 8'h88);
    do_req(64'h1040, make_block(8'h88));
    wait_done(1);
    check("err_bid", 64'(wb_error), 1);
    bid = 4'd0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/riscv_core_dcache_writeback.md
Name: riscv_core_dcache_writeback

Overview:
AXI4 write-master for the data cache. It accepts one evicted dirty 256-bit cache block plus its address from the dcache controller and buffers it. It then emits the block as a single INCR write burst on the AXI AW/W channels and waits for the B response. It is the outbound counterpart of the refill path that delivers blocks from AXI into the data array.

Parameters:
ADDR_WIDTH, 64, address width of the core and AXI.
BLOCK_WIDTH, 256, cache block width in bits (32 bytes).
AXI_DATA_WIDTH, 64, AXI write data bus width. BEATS = BLOCK_WIDTH/AXI_DATA_WIDTH = 4.
ID_WIDTH, 4, AXI ID width.
WB_ID, 0, constant AWID used for every writeback burst.

Ports:
i_clk  input  1  clock
i_rst_n  input  1  asynchronous active-low reset
i_wb_req  input  1  controller requests writeback of a block
i_wb_addr  input  ADDR_WIDTH  any byte address within the victim block
i_wb_block  input  BLOCK_WIDTH  victim block data; byte n at bits [8n+7:8n]
o_wb_ready  output  1  buffer empty; request is accepted when i_wb_req && o_wb_ready
o_wb_done  output  1  one-cycle pulse when B response is received
o_awid  output  ID_WIDTH  = WB_ID
o_awaddr  output  ADDR_WIDTH  block-aligned address (low 5 bits zero)
o_awlen  output  8  = BEATS-1 (3)
o_awsize  output  3  = log2(AXI_DATA_WIDTH/8) (3)
o_awburst  output  2  = 2'b01 (INCR)
o_awvalid  output  1  address valid
i_awready  input  1  address ready
o_wdata  output  AXI_DATA_WIDTH  current beat data
o_wstrb  output  AXI_DATA_WIDTH/8  all ones
o_wlast  output  1  high on beat BEATS-1
o_wvalid  output  1  data valid
i_wready  input  1  data ready
i_bid  input  ID_WIDTH  response ID (ignored unless the optional feature is enabled)
i_bresp  input  2  write response
i_bvalid  input  1  response valid
o_bready  output  1  response ready

Behaviour:
- Reset values: o_wb_ready=1. All of the following are 0: o_awvalid, o_wvalid, o_wlast, o_bready, o_wb_done, the beat counter and the internal buffers. Reset mid-burst aborts immediately and discards the buffered block.
- States: IDLE, SEND, RESP.
- IDLE: o_wb_ready=1.
  - On i_wb_req, capture {i_wb_addr[ADDR_WIDTH-1:5],5'b0} and i_wb_block into internal registers, clear aw_done and the beat counter, and go to SEND.
  - o_wb_ready drops to 0 in the cycle after acceptance.
- SEND: o_awvalid=!aw_done and o_wvalid=(beat<=BEATS-1 && !w_done), both asserted in the first SEND cycle.
  - AW and W handshakes are independent. W beats are not held until AW completes.
  - An AW handshake (o_awvalid && i_awready) sets aw_done.
  - A W handshake increments beat. Beat k drives o_wdata = block[k*AXI_DATA_WIDTH +: AXI_DATA_WIDTH], so word k matches address bits [4:3]=k.
  - o_wlast=1 only when beat==BEATS-1. The handshake on that beat sets w_done.
  - Leave SEND once aw_done and w_done are both set, counting handshakes that complete this cycle. Go to RESP.
- AXI rule: once asserted, o_awvalid, o_wvalid and their payloads stay stable until the corresponding ready.
- RESP: o_bready=1. On i_bvalid, o_wb_done pulses for exactly one cycle (registered, in the cycle after the B handshake) and the FSM returns to IDLE. o_wb_ready=1 in that same cycle.
- Only one writeback is outstanding at a time. i_wb_req outside IDLE is ignored; the controller must hold it until accepted.
- Back-to-back: a request presented in the cycle o_wb_ready returns is accepted. Minimum occupancy with zero-wait slaves is 1 (accept) + 4 (SEND) + 1 (RESP) cycles.
- BRESP value is ignored in the base build.

Optional Feature:
RISCV_DCACHE_WB_ERR_EN
- Defined: adds output o_wb_error (1 bit, reset 0).
- It is set sticky when the B handshake carries i_bresp[1]==1 (SLVERR/DECERR) or i_bid!=WB_ID. It is cleared only by reset.
- o_wb_done still pulses on an error response.
- Not defined: the port and its logic are absent, and behaviour is otherwise identical.

Test Plan:
- Zero-wait burst: addr 0x0000_1234, block bytes 0x00..0x1F.
  - o_awaddr=0x1220, awlen=3, awsize=3, awburst=1.
  - W beats 0x0706050403020100, 0x0F0E..08, 0x1716..10, 0x1F1E..18, with wlast on beat 3.
  - o_wb_done pulses once, 6 cycles after acceptance.
- Backpressure: i_awready held 0 for 5 cycles while i_wready=1.
  - All 4 W beats complete before AW.
  - AWADDR stays stable.
  - RESP is entered only after AW handshake.
- Intermittent i_wready (toggling 1/0): o_wdata and o_wlast are stable while stalled, and exactly 4 beats are transferred.
- Busy request: i_wb_req asserted during SEND with a different address is ignored. It is accepted on the first cycle after o_wb_done with o_wb_ready=1, and the second burst carries the second address.
- Reset mid-burst after beat 1: all valids go to 0 immediately and o_wb_ready=1. The next request starts fresh at beat 0.
- RISCV_DCACHE_WB_ERR_EN: i_bresp=2'b10 → o_wb_error=1 and stays 1 through a following OKAY burst. i_bid=5 with WB_ID=0 also sets it.
